gfx256_pixel_reader: RTL and testbench

- Read-side counterpart of the gfx256 pixel render path.
- Given a pixel coordinate, computes its 256-bit-line address in the render target, issues a read on the wishbone-master read port, and extracts the pixel colour from the returned line.
- Optionally performs a second read of the z-buffer line and extracts the 16-bit depth.
- Feeds blending, depth-test and blit-source stages.

---
 rtl/gfx256_pkg.sv | 30 +++
 rtl/gfx256_pixel_reader_if.sv | 16 +
 rtl/memory_to_color256.sv | 26 ++
 rtl/gfx256_pixel_reader.sv | 205 ++++++++++++++++++++
 tb/tb_gfx256_pixel_reader.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gfx256_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gfx256_pkg
// Brief    : Shared gfx256 encodings, reader state type and pixel offset helper
// Revision : 1.0 - initial release
// ============================================================================
package gfx256_pkg;

   localparam logic [1:0] CD_8  = 2'b00;
   localparam logic [1:0] CD_16 = 2'b01;
   localparam logic [1:0] CD_32 = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RD_PIX = 2'd1,
      ST_RD_Z   = 2'd2
   } reader_state_t;

   // Byte offset of a linear pixel index; 2'b11 behaves as 32bpp.
   function automatic logic [31:0] fnPixelOffset(input logic [31:0] idx,
                                                 input logic [1:0]  depth);
      case (depth)
         CD_8:    return idx;
         CD_16:   return {idx[30:0], 1'b0};
         default: return {idx[29:0], 2'b00};
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/gfx256_pixel_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : gfx256_pixel_reader_if
// Brief    : 256-bit line read port between the pixel reader and memory
// Revision : 1.0 - initial release
// ============================================================================
interface gfx256_pixel_reader_if;
   logic         read_o;
   logic [31:5]  read_addr_o;
   logic         ack_i;
   logic [255:0] dat_i;

   modport master (output read_o, output read_addr_o, input ack_i, input dat_i);
   modport slave  (input read_o, input read_addr_o, output ack_i, output dat_i);
endinterface
`default_nettype wire

// File: rtl/memory_to_color256.sv
`default_nettype none
// ============================================================================
// Module   : memory_to_color256
// Brief    : Combinational lane extraction of one pixel from a 256-bit line
// Revision : 1.0 - initial release
// ============================================================================
module memory_to_color256
   import gfx256_pkg::*;
(
   input  wire logic [1:0]   i_color_depth,
   input  wire logic [4:0]   i_lane,
   input  wire logic [255:0] i_line,
   output logic      [31:0]  o_color
);

   always_comb begin
      o_color = 32'd0;
      case (i_color_depth)
         CD_8:    o_color = {24'd0, i_line[{i_lane, 3'b000} +: 8]};
         CD_16:   o_color = {16'd0, i_line[{i_lane[4:1], 4'b0000} +: 16]};
         default: o_color = i_line[{i_lane[4:2], 5'b00000} +: 32];
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/gfx256_pixel_reader.sv
`default_nettype none
// ============================================================================
// Module   : gfx256_pixel_reader
// Brief    : Fetches a pixel colour (and optional 16-bit depth) by line reads.
//            Define GFX256_READER_CACHE_EN for a one-entry pixel line cache.
// Revision : 1.0 - initial release
// ============================================================================
module gfx256_pixel_reader
   import gfx256_pkg::*;
#(
   parameter int POINT_WIDTH = 16
) (
   input  wire logic                   clk_i,
   input  wire logic                   rst_i,
   input  wire logic [31:5]            target_base_i,
   input  wire logic [31:5]            zbuffer_base_i,
   input  wire logic [POINT_WIDTH-1:0] target_size_x_i,
   input  wire logic [1:0]             color_depth_i,
   input  wire logic                   zbuffer_enable_i,
   input  wire logic [POINT_WIDTH-1:0] pixel_x_i,
   input  wire logic [POINT_WIDTH-1:0] pixel_y_i,
   input  wire logic                   read_i,
   input  wire logic                   invalidate_i,
   gfx256_pixel_reader_if.master       mem,
   output logic                        ack_o,
   output logic                        busy_o,
   output logic [31:0]                 color_o,
   output logic [POINT_WIDTH-1:0]      z_o
);

   reader_state_t r_state, w_state_nxt;
   logic          r_read, w_read_nxt;
   logic [31:5]   r_addr, w_addr_nxt;
   logic          w_ack_nxt, w_busy_nxt;
   logic          w_color_cap, w_z_cap, w_accept, w_fill;
   logic [31:5]   r_zline;
   logic [4:0]    r_tlane, r_zlane;
   logic [1:0]    r_depth;
   logic          r_zen;

   logic [31:0]   w_idx, w_byte_off, w_z_off;
   logic [31:5]   w_tline, w_zline;
   logic          w_hit;
   logic [255:0]  w_line;
   logic [1:0]    w_sel_depth;
   logic [4:0]    w_sel_lane;
   logic [31:0]   w_color, w_z_color;
   logic          w_z_unused;

   assign w_idx      = 32'(target_size_x_i) * 32'(pixel_y_i) + 32'(pixel_x_i);
   assign w_byte_off = fnPixelOffset(w_idx, color_depth_i);
   assign w_z_off    = fnPixelOffset(w_idx, CD_16);
   assign w_tline    = target_base_i + w_byte_off[31:5];
   assign w_zline    = zbuffer_base_i + w_z_off[31:5];

   // In IDLE the only capture is a cache hit, taken straight from the live request.
   assign w_sel_depth = (r_state == ST_IDLE) ? color_depth_i    : r_depth;
   assign w_sel_lane  = (r_state == ST_IDLE) ? w_byte_off[4:0]  : r_tlane;

`ifdef GFX256_READER_CACHE_EN
   logic         r_valid;
   logic [31:5]  r_tag;
   logic [255:0] r_cache_line;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid      <= 1'b0;
         r_tag        <= '0;
         r_cache_line <= '0;
      end else begin
         if (invalidate_i)
            r_valid <= 1'b0;
         else if (w_fill)
            r_valid <= 1'b1;
         if (w_fill) begin
            r_tag        <= r_addr;
            r_cache_line <= mem.dat_i;
         end
      end
   end

   assign w_hit  = r_valid && (r_tag == w_tline);
   assign w_line = (r_state == ST_IDLE) ? r_cache_line : mem.dat_i;
`else
   logic w_cache_unused;
   assign w_hit          = 1'b0;
   assign w_line         = mem.dat_i;
   assign w_cache_unused = invalidate_i ^ w_fill;
`endif

   memory_to_color256 u_pix_extract (
      .i_color_depth (w_sel_depth),
      .i_lane        (w_sel_lane),
      .i_line        (w_line),
      .o_color       (w_color)
   );

   memory_to_color256 u_z_extract (
      .i_color_depth (CD_16),
      .i_lane        (r_zlane),
      .i_line        (mem.dat_i),
      .o_color       (w_z_color)
   );

   assign w_z_unused = ^w_z_color;

   always_comb begin
      w_state_nxt = r_state;
      w_read_nxt  = r_read;
      w_addr_nxt  = r_addr;
      w_ack_nxt   = 1'b0;
      w_busy_nxt  = busy_o;
      w_color_cap = 1'b0;
      w_z_cap     = 1'b0;
      w_accept    = 1'b0;
      w_fill      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (read_i) begin
               w_accept   = 1'b1;
               w_busy_nxt = 1'b1;
               if (w_hit) begin
                  w_color_cap = 1'b1;
                  if (zbuffer_enable_i) begin
                     w_state_nxt = ST_RD_Z;
                     w_read_nxt  = 1'b1;
                     w_addr_nxt  = w_zline;
                  end else begin
                     w_ack_nxt  = 1'b1;
                     w_busy_nxt = 1'b0;
                  end
               end else begin
                  w_state_nxt = ST_RD_PIX;
                  w_read_nxt  = 1'b1;
                  w_addr_nxt  = w_tline;
               end
            end
         end
         ST_RD_PIX: begin
            if (mem.ack_i) begin
               w_color_cap = 1'b1;
               w_fill      = 1'b1;
               if (r_zen) begin
                  w_state_nxt = ST_RD_Z;
                  w_addr_nxt  = r_zline;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_read_nxt  = 1'b0;
                  w_ack_nxt   = 1'b1;
                  w_busy_nxt  = 1'b0;
               end
            end
         end
         ST_RD_Z: begin
            if (mem.ack_i) begin
               w_z_cap     = 1'b1;
               w_state_nxt = ST_IDLE;
               w_read_nxt  = 1'b0;
               w_ack_nxt   = 1'b1;
               w_busy_nxt  = 1'b0;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_read  <= 1'b0;
         r_addr  <= '0;
         ack_o   <= 1'b0;
         busy_o  <= 1'b0;
         color_o <= '0;
         z_o     <= '0;
         r_zline <= '0;
         r_tlane <= '0;
         r_zlane <= '0;
         r_depth <= CD_8;
         r_zen   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_read  <= w_read_nxt;
         r_addr  <= w_addr_nxt;
         ack_o   <= w_ack_nxt;
         busy_o  <= w_busy_nxt;
         if (w_color_cap)
            color_o <= w_color;
         if (w_z_cap)
            z_o <= w_z_color[POINT_WIDTH-1:0];
         if (w_accept) begin
            r_zline <= w_zline;
            r_tlane <= w_byte_off[4:0];
            r_zlane <= w_z_off[4:0];
            r_depth <= color_depth_i;
            r_zen   <= zbuffer_enable_i;
         end
      end
   end

   assign mem.read_o      = r_read;
   assign mem.read_addr_o = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_gfx256_pixel_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_gfx256_pixel_reader
// Brief    : Self-checking bench for gfx256_pixel_reader against a line model
// Revision : 1.0 - initial release
// ============================================================================
module tb_gfx256_pixel_reader;

`ifdef GFX256_READER_CACHE_EN
   localparam bit CACHE_EN = 1'b1;
`else
   localparam bit CACHE_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:5] target_base = '0, zbuffer_base = '0;
   logic [15:0] size_x = '0, px = '0, py = '0;
   logic [1:0]  cd = '0;
   logic        zen = 1'b0, read_req = 1'b0, invalidate = 1'b0;
   logic        ack_out, busy;
   logic [31:0] color;
   logic [15:0] z;

   gfx256_pixel_reader_if mem_if ();

   gfx256_pixel_reader #(.POINT_WIDTH(16)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .target_base_i    (target_base),
      .zbuffer_base_i   (zbuffer_base),
      .target_size_x_i  (size_x),
      .color_depth_i    (cd),
      .zbuffer_enable_i (zen),
      .pixel_x_i        (px),
      .pixel_y_i        (py),
      .read_i           (read_req),
      .invalidate_i     (invalidate),
      .mem              (mem_if),
      .ack_o            (ack_out),
      .busy_o           (busy),
      .color_o          (color),
      .z_o              (z)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference state: last captured results and the modelled cache entry.
   logic [31:0]  m_color = '0;
   logic [15:0]  m_z     = '0;
   bit           m_valid = 1'b0;
   logic [26:0]  m_tag   = '0;
   logic [255:0] m_line  = '0;
   bit           force_b31 = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [31:0] extract(input logic [255:0] line, input logic [4:0] lowb,
                                           input int bpp);
      logic [255:0] s;
      s = line >> (int'(lowb) * 8);
      if (bpp == 1) return {24'd0, s[7:0]};
      if (bpp == 2) return {16'd0, s[15:0]};
      return s[31:0];
   endfunction

   task automatic txn(input logic [15:0] sx, input logic [15:0] x, input logic [15:0] y,
                      input logic [1:0] d, input logic ze, input logic [26:0] tb,
                      input logic [26:0] zb, input int dp, input int dz, input bit poke);
      logic [31:0]  idx, boff, zoff;
      logic [26:0]  tl, zl;
      logic [255:0] pl, zlne;
      int           bpp;
      bit           hit;
      idx  = 32'(sx) * 32'(y) + 32'(x);
      bpp  = (d == 2'b00) ? 1 : (d == 2'b01) ? 2 : 4;
      boff = idx * 32'(bpp);
      zoff = idx * 32'd2;
      tl   = 27'(32'(tb) + boff / 32);
      zl   = 27'(32'(zb) + zoff / 32);
      pl   = rand_line();
      zlne = rand_line();
      if (force_b31) pl[255:248] = 8'hAB;
      hit  = CACHE_EN && m_valid && (m_tag == tl);

      size_x = sx; px = x; py = y; cd = d; zen = ze;
      target_base = tb; zbuffer_base = zb;
      read_req = 1'b1;
      step();
      read_req = 1'b0;
      px = 16'($urandom); py = 16'($urandom); cd = 2'($urandom);
      zen = 1'($urandom); target_base = 27'($urandom); zbuffer_base = 27'($urandom);

      if (hit) begin
         check("hit_no_read", 32'(mem_if.read_o), 32'(ze));
         m_color = extract(m_line, boff[4:0], bpp);
      end else begin
         check("busy_accept", 32'(busy), 32'd1);
         check("read_req", 32'(mem_if.read_o), 32'd1);
         check("pix_addr", 32'(mem_if.read_addr_o), 32'(tl));
         check("ack_early", 32'(ack_out), 32'd0);
         for (int i = 0; i < dp; i++) begin
            if (poke && i == 1) read_req = 1'b1;
            step();
            read_req = 1'b0;
            check("read_held", 32'(mem_if.read_o), 32'd1);
            check("addr_held", 32'(mem_if.read_addr_o), 32'(tl));
            check("ack_wait", 32'(ack_out), 32'd0);
         end
         mem_if.ack_i = 1'b1; mem_if.dat_i = pl;
         step();
         mem_if.ack_i = 1'b0; mem_if.dat_i = rand_line();
         m_color = extract(pl, boff[4:0], bpp);
         if (CACHE_EN) begin
            m_valid = 1'b1; m_tag = tl; m_line = pl;
         end
      end
      check("color", color, m_color);

      if (ze) begin
         check("z_read", 32'(mem_if.read_o), 32'd1);
         check("z_addr", 32'(mem_if.read_addr_o), 32'(zl));
         check("ack_before_z", 32'(ack_out), 32'd0);
         for (int i = 0; i < dz; i++) begin
            step();
            check("z_addr_held", 32'(mem_if.read_addr_o), 32'(zl));
         end
         mem_if.ack_i = 1'b1; mem_if.dat_i = zlne;
         step();
         mem_if.ack_i = 1'b0; mem_if.dat_i = rand_line();
         m_z = 16'(extract(zlne, zoff[4:0], 2));
         check("color_kept", color, m_color);
      end

      check("ack_pulse", 32'(ack_out), 32'd1);
      check("read_done", 32'(mem_if.read_o), 32'd0);
      check("busy_done", 32'(busy), 32'd0);
      check("z_val", 32'(z), 32'(m_z));
      step();
      check("ack_single", 32'(ack_out), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      mem_if.ack_i = 1'b0;
      mem_if.dat_i = '0;
      #1 rst = 1'b1;
      #1;
      check("rst_read", 32'(mem_if.read_o), 32'd0);
      check("rst_addr", 32'(mem_if.read_addr_o), 32'd0);
      check("rst_ack", 32'(ack_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_color", color, 32'd0);
      check("rst_z", 32'(z), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // Directed cases: 32bpp stride 640, 8bpp last lane, 16bpp with depth, stalls
      txn(16'd640, 16'd3, 16'd2, 2'b10, 1'b0, 27'h0000100, 27'h0000800, 0, 0, 1'b0);
      force_b31 = 1'b1;
      txn(16'd640, 16'd31, 16'd0, 2'b00, 1'b0, 27'h0000000, 27'h0000800, 0, 0, 1'b0);
      force_b31 = 1'b0;
      check("b31", color, 32'h000000AB);
      txn(16'd640, 16'd17, 16'd0, 2'b01, 1'b1, 27'h0000200, 27'h0000800, 0, 0, 1'b0);
      txn(16'd100, 16'd9, 16'd7, 2'b10, 1'b0, 27'h0001000, 27'h0000800, 5, 0, 1'b1);

      for (int i = 0; i < 24; i++) begin
         txn(16'($urandom_range(1, 65535)), 16'($urandom), 16'($urandom),
             2'($urandom_range(0, 3)), 1'($urandom), 27'($urandom), 27'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b1);
         if (i % 4 == 3)
            txn(16'd64, 16'd5, 16'd1, 2'b01, 1'($urandom), 27'h0002000, 27'h0004000,
                1, 1, 1'b0);
      end

      // Reset while waiting on the depth line
      size_x = 16'd32; px = 16'd4; py = 16'd1; cd = 2'b01; zen = 1'b1;
      target_base = 27'h0003000; zbuffer_base = 27'h0005000;
      read_req = 1'b1;
      step();
      read_req = 1'b0;
      mem_if.ack_i = 1'b1; mem_if.dat_i = rand_line();
      step();
      mem_if.ack_i = 1'b0;
      check("rdz_reached", 32'(mem_if.read_o), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("arst_read", 32'(mem_if.read_o), 32'd0);
      check("arst_addr", 32'(mem_if.read_addr_o), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_color", color, 32'd0);
      check("arst_z", 32'(z), 32'd0);
      m_color = '0; m_z = '0; m_valid = 1'b0;
      @(negedge clk) rst = 1'b0;
      mem_if.ack_i = 1'b1;
      step();
      mem_if.ack_i = 1'b0;
      check("late_ack", 32'(ack_out), 32'd0);
      check("late_read", 32'(mem_if.read_o), 32'd0);

      // Same line twice, then invalidate and read it again
      txn(16'd640, 16'd3, 16'd2, 2'b10, 1'b0, 27'h0000100, 27'h0000800, 0, 0, 1'b0);
      txn(16'd640, 16'd2, 16'd2, 2'b10, 1'b0, 27'h0000100, 27'h0000800, 0, 0, 1'b0);
      txn(16'd640, 16'd0, 16'd2, 2'b10, 1'b1, 27'h0000100, 27'h0000800, 0, 0, 1'b0);
      invalidate = 1'b1;
      step();
      invalidate = 1'b0;
      m_valid = 1'b0;
      txn(16'd640, 16'd3, 16'd2, 2'b10, 1'b0, 27'h0000100, 27'h0000800, 0, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
